// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised sync FIFO.
// Pointer-width function, default geometry, elaboration-time checks.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(
    input int depth,
    input int af,
    input int ae
  );
    return (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array: one write port, one registered read port.
// Ports: we/waddr/wdata write; re/raddr read into rdata; clr zeroes rdata.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_d, rdata_q;

  // Same-address read/write returns the old word.
  always_comb begin
    rdata_d = rdata_q;
    if (clr)     rdata_d = '0;
    else if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost flags and optional sticky errors.
// Ports: clk, rst_n (sync, low), wr_en/data_in, rd_en/data_out, fifo_counter,
// fifo_full/empty, almost_full/empty, overflow/underflow, err_clr.
// Macro SYNC_FIFO_ERR_FLAGS_EN enables overflow/underflow; else tied to 0.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [$clog2(DEPTH):0]   fifo_counter,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thr
    $error("sync_fifo_param: threshold out of range");
  end

  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          full_d, full_q;
  logic          empty_d, empty_q;
  logic          af_d, af_q;
  logic          ae_d, ae_q;
  logic          ovf_d, ovf_q;
  logic          unf_d, unf_q;
  logic          rd_acc, wr_acc;

  assign rd_acc = rd_en & ~empty_q;
  // Full FIFO still takes a write when the read frees a slot this cycle.
  assign wr_acc = wr_en & (~full_q | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (!rst_n) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      // Set beats clear when both land in one cycle.
      ovf_d = ERR_EN & ((ovf_q & ~err_clr) | (wr_en & ~wr_acc));
      unf_d = ERR_EN & ((unf_q & ~err_clr) | (rd_en & ~rd_acc));
    end
    full_d  = (cnt_d == FULL_C);
    empty_d = (cnt_d == '0);
    af_d    = (cnt_d >= AF_C);
    ae_d    = (cnt_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    cnt_q    <= cnt_d;
    full_q   <= full_d;
    empty_q  <= empty_d;
    af_q     <= af_d;
    ae_q     <= ae_d;
    ovf_q    <= ovf_d;
    unf_q    <= unf_d;
  end

  sync_fifo_ram #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .clr   (~rst_n),
    .we    (wr_acc & rst_n),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign fifo_counter = cnt_q;
  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed + random bench for sync_fifo_param with a queue scoreboard.
// Checks occupancy, flags, read data and sticky error flags each cycle.
module tb_sync_fifo_param;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int AF  = 14;
  localparam int AE  = 2;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_out;
  logic [4:0]    fifo_counter;
  logic          fifo_full, fifo_empty;
  logic          almost_full, almost_empty;
  logic          overflow, underflow;
  logic          err_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] m_dout;
  logic          m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .fifo_counter (fifo_counter),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = sb.size();
    chk({tag, ".cnt"},   32'(fifo_counter), 32'(n));
    chk({tag, ".empty"}, 32'(fifo_empty),   32'(n == 0));
    chk({tag, ".full"},  32'(fifo_full),    32'(n == DEP));
    chk({tag, ".af"},    32'(almost_full),  32'(n >= AF));
    chk({tag, ".ae"},    32'(almost_empty), 32'(n <= AE));
    chk({tag, ".dout"},  32'(data_out),     32'(m_dout));
    chk({tag, ".ovf"},   32'(overflow),     32'(m_ovf));
    chk({tag, ".unf"},   32'(underflow),    32'(m_unf));
  endtask

  // One clock: drive at negedge, model the edge, sample 1 ns later.
  task automatic step(
    input string   tag,
    input bit      rst,
    input bit      wr,
    input [DW-1:0] din,
    input bit      rd,
    input bit      clr
  );
    bit ra, wa;
    @(negedge clk);
    rst_n   = ~rst;
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    err_clr = clr;
    if (rst) begin
      sb.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      ra = rd && (sb.size() > 0);
      wa = wr && ((sb.size() < DEP) || rd);
      if (ra) m_dout = sb.pop_front();
      if (wa) sb.push_back(din);
      m_ovf = ERR_EN & ((m_ovf & ~clr) | (wr & ~wa));
      m_unf = ERR_EN & ((m_unf & ~clr) | (rd & ~ra));
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;

    // Reset held for two edges.
    step("rst0", 1, 0, 8'h00, 0, 0);
    step("rst1", 1, 0, 8'h00, 0, 0);

    // Fill 0x00..0x0F then drain in order.
    for (int i = 0; i < DEP; i++)
      step("fill", 0, 1, 8'(i), 0, 0);
    chk("af_at16", 32'(almost_full), 32'd1);
    chk("full_at16", 32'(fifo_full), 32'd1);
    for (int i = 0; i < DEP; i++) begin
      step("drain", 0, 0, 8'h00, 1, 0);
      chk("drain_order", 32'(data_out), 32'(i));
    end
    chk("empty_end", 32'(fifo_empty), 32'd1);

    // Full with simultaneous read and write.
    for (int i = 0; i < DEP; i++)
      step("fill2", 0, 1, 8'(8'h10 + i), 0, 0);
    step("full_rw", 0, 1, 8'hA5, 1, 0);
    chk("full_rw_old", 32'(data_out), 32'h10);
    chk("full_rw_cnt", 32'(fifo_counter), 32'd16);

    // Rejected write while full.
    step("ovf", 0, 1, 8'h77, 0, 0);
    chk("ovf_cnt", 32'(fifo_counter), 32'd16);
    for (int i = 0; i < DEP; i++)
      step("drain2", 0, 0, 8'h00, 1, 0);
    chk("a5_last", 32'(data_out), 32'hA5);

    // Rejected read while empty, then clear.
    step("unf", 0, 0, 8'h00, 1, 0);
    step("clr", 0, 0, 8'h00, 0, 1);

    // Empty with simultaneous read and write: no fall-through.
    step("empty_rw", 0, 1, 8'h3C, 1, 0);
    chk("empty_rw_cnt", 32'(fifo_counter), 32'd1);
    chk("empty_rw_dout", 32'(data_out), 32'hA5);
    step("rd_3c", 0, 0, 8'h00, 1, 0);
    chk("rd_3c_val", 32'(data_out), 32'h3C);
    step("clr2", 0, 0, 8'h00, 0, 1);

    // Random traffic across pointer wrap.
    for (int i = 0; i < 40; i++)
      step("rand", 0, 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 0);

    // Bring occupancy to 9, then reset mid-operation.
    for (int i = 0; i < 32 && sb.size() != 9; i++) begin
      if (sb.size() < 9)
        step("to9w", 0, 1, 8'($urandom_range(0, 255)), 0, 0);
      else
        step("to9r", 0, 0, 8'h00, 1, 0);
    end
    chk("cnt9", 32'(fifo_counter), 32'd9);
    step("midrst", 1, 1, 8'hEE, 1, 0);
    chk("midrst_cnt", 32'(fifo_counter), 32'd0);
    chk("midrst_dout", 32'(data_out), 32'h00);
    step("post", 0, 0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the successor to the fixed 16x8 synchronous FIFO. Generalises data width and depth, adds programmable almost-full/almost-empty flags, accepts a write on a full FIFO when a read happens in the same cycle, and optionally adds sticky overflow/underflow error flags. It is the standard rate-matching buffer between producer and consumer blocks in the same clock domain.

## Interface
- DATA_WIDTH, 8: word width in bits, ≥1
- DEPTH, 16: number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH; 1..DEPTH
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH; 0..DEPTH-1
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, **synchronous, active-low**
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data, registered
- fifo_counter  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- err_clr  in  1  clears overflow/underflow

## Operation
- Pointers: wr_ptr, rd_ptr, each $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0. Occupancy is held in fifo_counter, not derived from pointers.
- rd_acc = rd_en & !fifo_empty.
- wr_acc = wr_en & (!fifo_full | rd_en). A write to a full FIFO is accepted only when a read is accepted in the same cycle.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither are accepted.
- Read on empty with a simultaneous write: the read is rejected, the write is accepted, and the count goes 0→1. There is no fall-through.
- Accepted write: mem[wr_ptr] <= data_in, then wr_ptr+1. Accepted read: data_out <= mem[rd_ptr], then rd_ptr+1. data_out holds its value when no read is accepted.
- Simultaneous accepted read and write on a full FIFO: the read returns the oldest word, and the new word lands in the slot just vacated (wr_ptr == rd_ptr).
- All flags are registered and computed from the next count, so they are valid in the same cycle as fifo_counter.
- Reset (rst_n=0 at a clk edge): pointers=0, fifo_counter=0, data_out=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0), overflow=0, underflow=0. Memory contents are not reset. Reset in mid-operation discards all stored data; requests in the reset cycle are ignored.

## Timing
- Write-to-read latency: a word written at edge N can be read at edge N+1. data_out is valid after the edge at which rd_acc is sampled high (1-cycle read latency).
- fifo_counter and all flags update on the same edge as the accepted operation.
- No combinational path from any input to any output.

## Configuration
- SYNC_FIFO_ERR_FLAGS_EN defined:
  - overflow sets on wr_en & !wr_acc.
  - underflow sets on rd_en & !rd_acc.
  - Both flags are sticky until err_clr=1 at a clk edge. If a set and err_clr occur in the same cycle, set wins.
- SYNC_FIFO_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0, and err_clr is ignored. The ports remain present.

## Structure
- Package sync_fifo_pkg:
  - Function for the pointer width.
  - Default DATA_WIDTH and DEPTH constants.
  - Elaboration checks: DEPTH is a power of two; thresholds are in range.
- Sub-module sync_fifo_ram: simple dual-port array with one write port and one registered read port with enable and synchronous clear of the output register. The top level holds the pointers, count, flags and error logic.

## Test plan
Configuration for all scenarios: DATA_WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2, SYNC_FIFO_ERR_FLAGS_EN defined.
- Reset: hold rst_n=0 for 2 edges → fifo_counter=0, fifo_empty=1, almost_empty=1, data_out=0x00, all other flags 0.
- Fill and drain: write 0x00..0x0F → almost_full after the 14th write, fifo_full after the 16th. Then read 16 words → data_out shows 0x00..0x0F in order, one cycle after each read; fifo_empty=1 at the end.
- Full with simultaneous read/write: with the FIFO full, assert wr_en=1 (data 0xA5) and rd_en=1 → data_out=oldest word, fifo_counter stays 16, overflow stays 0. 0xA5 is read out last after draining.
- Overflow/underflow: write while full with rd_en=0 → overflow=1, fifo_counter stays 16. Read while empty with wr_en=0 → underflow=1. Pulse err_clr → both flags 0.
- Empty with simultaneous read/write: with the FIFO empty, assert wr_en=1 (0x3C) and rd_en=1 → fifo_counter=1, data_out unchanged, underflow=1. The next read returns 0x3C.
- Wrap and mid-operation reset: run 40 cycles of random rd/wr against a reference model, checking pointer wrap and data order. Assert rst_n=0 with the count at 9 → after the edge, fifo_counter=0, fifo_empty=1, and data_out=0x00.
